// File: rtl/parity_scrubber_if.sv
// Scrub read port between the scrubber and the memory port mux.
// The memory side answers a read one cycle after read_enable.
interface parity_scrubber_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     read_enable;
    logic [ADDRESS_WIDTH-1:0] read_address;
    logic [DATA_WIDTH:0]      read_block;
    logic                     memory_busy;

    modport master (
        output read_enable,
        output read_address,
        input  read_block,
        input  memory_busy
    );

    modport slave (
        input  read_enable,
        input  read_address,
        output read_block,
        output memory_busy
    );
endinterface

// File: rtl/parity_scrubber.sv
// Background even-parity scrubber: sweeps all addresses, yields to
// functional traffic, and logs a saturating error count and first failure.
module parity_scrubber #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     abort,
    input  logic                     clear_errors,
    parity_scrubber_if.master        mem,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     error_pulse,
    output logic [COUNT_WIDTH-1:0]   error_count,
    output logic                     first_error_valid,
    output logic [ADDRESS_WIDTH-1:0] first_error_address
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     check_valid;
    logic [ADDRESS_WIDTH-1:0] check_address;
    logic                     issue;
    logic                     fail;

    // abort gates the strobe so no read escapes in the abort cycle
    assign issue = (state == SWEEP) && !mem.memory_busy && !abort;
    assign mem.read_enable  = issue;
    assign mem.read_address = address;
    assign busy = (state != IDLE);
    assign fail = check_valid && (^mem.read_block);

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            address             <= '0;
            check_valid         <= 1'b0;
            check_address       <= '0;
            sweep_done          <= 1'b0;
            error_pulse         <= 1'b0;
            error_count         <= '0;
            first_error_valid   <= 1'b0;
            first_error_address <= '0;
        end else begin
            sweep_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= SWEEP;
                        address <= '0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state   <= IDLE;
                        address <= '0;
                    end else if (issue) begin
                        if (address == LAST) state <= DRAIN;
                        else address <= address + 1'b1;
                    end
                end
                DRAIN: begin
                    address <= '0;
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        sweep_done <= 1'b1;
                        state      <= continuous ? SWEEP : IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    address <= '0;
                end
            endcase

            // checks in flight complete even across an abort
            check_valid   <= issue;
            check_address <= address;
            error_pulse   <= fail;

            // a coincident clear wipes history first, then logs the failure
            if (clear_errors) begin
                error_count         <= fail ? COUNT_WIDTH'(1) : '0;
                first_error_valid   <= fail;
                first_error_address <= fail ? check_address : '0;
            end else if (fail) begin
                if (error_count != COUNT_MAX) error_count <= error_count + 1'b1;
                if (!first_error_valid) begin
                    first_error_valid   <= 1'b1;
                    first_error_address <= check_address;
                end
            end
        end
    end

endmodule

// File: doc/parity_scrubber.md
Name: parity_scrubber

Overview:
Background scrubber for a parity-protected memory holding DATA_WIDTH+1-bit blocks, with the parity code in the MSB. On a start request, it sweeps every address by issuing reads, checks each returned block for even-parity consistency, and yields to functional traffic whenever the memory is busy. It logs a saturating error count and the first failing address for software, and sits between the memory port mux and the error-reporting/CSR logic.

Parameters:
DATA_WIDTH, 8, data bits per block; blocks are DATA_WIDTH+1 bits wide.
DEPTH, 16, number of memory entries swept; must be at least 2.
ADDRESS_WIDTH, $clog2(DEPTH), width of the address ports.
COUNT_WIDTH, 8, width of the saturating error counter.

Ports:
clock  input  1  system clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to begin a sweep; ignored while busy.
continuous  input  1  when high at sweep end, the next sweep starts immediately.
abort  input  1  stops the sweep; takes priority over start.
clear_errors  input  1  clears the error count and the first-error record.
memory_busy  input  1  functional access owns the port this cycle; no scrub read may be issued.
read_enable  output  1  scrub read strobe.
read_address  output  ADDRESS_WIDTH  scrub read address.
read_block  input  DATA_WIDTH+1  read data, valid exactly 1 cycle after read_enable.
busy  output  1  high in SWEEP and DRAIN.
sweep_done  output  1  1-cycle pulse when a sweep completes.
error_pulse  output  1  1-cycle pulse per failing block.
error_count  output  COUNT_WIDTH  saturating count of failing blocks.
first_error_valid  output  1  first_error_address holds a captured address.
first_error_address  output  ADDRESS_WIDTH  address of the first failure since the last clear.

Behaviour:
- Reset: state IDLE; all outputs 0; internal address 0; check stage invalid.
- States:
  - IDLE: a start pulse moves to SWEEP with address 0.
  - SWEEP: read_enable = !memory_busy, combinational. read_address = current address.
    - On an issued read at address < DEPTH-1, the address increments.
    - On an issued read at DEPTH-1, go to DRAIN.
    - While memory_busy is high, the address holds and no read is issued.
  - DRAIN: no read is issued. The next cycle pulses sweep_done. The state then becomes SWEEP at address 0 if continuous is high, else IDLE.
  - abort, in SWEEP or DRAIN: next state is IDLE, address 0, no sweep_done. A read issued in the abort cycle is suppressed (read_enable gated by abort).
- Check stage: check_valid and check_address are registered from the read issued last cycle. A read is issued every cycle the memory is free, with one-cycle pipelined checking.
  - Failure = check_valid and XOR-reduce(read_block) = 1 (odd overall parity).
  - A check whose read was issued before an abort still completes and is logged.
- On failure:
  - error_pulse is registered, asserting the cycle after the check.
  - error_count increments, saturating at 2^COUNT_WIDTH-1.
  - If first_error_valid is 0, capture check_address and set first_error_valid.
- clear_errors: error_count and first_error_valid go to 0. If a failure coincides, the clear applies first and the failure is then logged: count becomes 1 and its address is captured.
- Latency: a read issued at cycle N is checked at N+1; error_pulse and the count update are visible at N+2.
- Minimum sweep with memory_busy always low: DEPTH cycles in SWEEP + 1 cycle in DRAIN. sweep_done is visible the cycle after DRAIN.
- No state changes outside these rules. A start while busy is dropped, not queued.

Test Plan:
1. Reset, then start, with memory_busy=0 and all blocks correct -> read_address runs 0..15 on consecutive cycles; sweep_done pulses once, 17 cycles after start is registered; error_count=0; busy returns to 0.
2. Corrupt addresses 5 and 11 by flipping bit 3, then sweep -> exactly two error_pulses; error_count=2; first_error_address=5 with first_error_valid=1.
3. Hold memory_busy high for cycles 3-6 of the sweep -> read_enable=0 during those cycles; no address is skipped or repeated; sweep_done is delayed by exactly 4 cycles.
4. Assert abort on the cycle address 7 is pending -> no read at 7; busy=0 next cycle; no sweep_done; a prior failure at address 6 is still counted.
5. Corrupt every block and set COUNT_WIDTH=4 with continuous=1 for 2 sweeps -> error_count saturates at 15; first_error_address=0.
6. Pulse clear_errors in the same cycle as a failure at address 9 -> error_count=1, first_error_address=9; a second start while busy is ignored.
